range_sequence_checker: RTL

Receive-side checker for the bounded range-counter stream, with LO=10 and HI=40 by default. It samples a count bus with a qualifying valid strobe and locks onto the LO..HI wrap sequence. Once locked, it flags any dropped, repeated, skipped or out-of-range value. It also maintains error and wrap statistics for debug and status registers on the consumer side of the counter.

---
 rtl/range_sequence_checker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/range_sequence_checker.sv
// Receive-side checker for a LO..HI wrapping counter stream: locks onto the
// sequence, flags violations once locked, and keeps error and wrap statistics.
module range_sequence_checker #(
   parameter int WIDTH  = 6,
   parameter int LO     = 10,
   parameter int HI     = 40,
   parameter int ERR_W  = 8,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              valid_in,
   input  logic              clear,
   output logic              locked,
   output logic [WIDTH-1:0]  expected,
   output logic              error,
   output logic              out_of_range,
   output logic [ERR_W-1:0]  err_count,
   output logic [WRAP_W-1:0] wrap_count
);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SEED     = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] LO_V    = WIDTH'(LO);
   localparam logic [WIDTH-1:0] HI_V    = WIDTH'(HI);
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t              state_r;
   logic                locked_r;
   logic [WIDTH-1:0]    expected_r;
   logic                error_r;
   logic                oor_r;
   logic [ERR_W-1:0]    err_r;
   logic [WRAP_W-1:0]   wrap_r;

   logic                in_range_s;
   logic                match_s;
   logic                err_event_s;
   logic                wrap_event_s;

   function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] n;
      if (x == HI_V) begin
         n = LO_V;
      end else begin
         n = x + WIDTH'(1);
      end
      return n;
   endfunction

   function automatic logic in_range_f(input logic [WIDTH-1:0] x);
      return (x >= LO_V) && (x <= HI_V);
   endfunction

   assign in_range_s   = in_range_f(count_in);
   assign match_s      = (count_in == expected_r);
   assign err_event_s  = valid_in && (state_r == ST_LOCKED) && !match_s;
   assign wrap_event_s = valid_in && (state_r == ST_LOCKED) && match_s && (count_in == LO_V);

   // Lock state machine, expected-value tracking and statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_UNLOCKED;
         locked_r   <= 1'b0;
         expected_r <= LO_V;
         error_r    <= 1'b0;
         oor_r      <= 1'b0;
         err_r      <= {ERR_W{1'b0}};
         wrap_r     <= {WRAP_W{1'b0}};
      end else begin
         error_r <= 1'b0;
         oor_r   <= 1'b0;

         // Clear takes priority over any increment on the same edge.
         if (clear) begin
            err_r  <= {ERR_W{1'b0}};
            wrap_r <= {WRAP_W{1'b0}};
         end else begin
            if (err_event_s && (err_r != ERR_MAX)) begin
               err_r <= err_r + ERR_W'(1);
            end
            if (wrap_event_s) begin
               wrap_r <= wrap_r + WRAP_W'(1);
            end
         end

         if (valid_in) begin
            case (state_r)
               ST_UNLOCKED: begin
                  if (in_range_s) begin
                     expected_r <= next_val(count_in);
                     state_r    <= ST_SEED;
                  end
               end
               ST_SEED: begin
                  if (!in_range_s) begin
                     state_r <= ST_UNLOCKED;
                  end else if (match_s) begin
                     expected_r <= next_val(count_in);
                     state_r    <= ST_LOCKED;
                     locked_r   <= 1'b1;
                  end else begin
                     expected_r <= next_val(count_in);
                  end
               end
               ST_LOCKED: begin
                  if (match_s) begin
                     expected_r <= next_val(count_in);
                  end else if (in_range_s) begin
                     error_r    <= 1'b1;
                     expected_r <= next_val(count_in);
                     state_r    <= ST_SEED;
                     locked_r   <= 1'b0;
                  end else begin
                     error_r    <= 1'b1;
                     oor_r      <= 1'b1;
                     expected_r <= LO_V;
                     state_r    <= ST_UNLOCKED;
                     locked_r   <= 1'b0;
                  end
               end
               default: begin
                  state_r    <= ST_UNLOCKED;
                  locked_r   <= 1'b0;
                  expected_r <= LO_V;
               end
            endcase
         end
      end
   end

   assign locked       = locked_r;
   assign expected     = expected_r;
   assign error        = error_r;
   assign out_of_range = oor_r;
   assign err_count    = err_r;
   assign wrap_count   = wrap_r;

endmodule
